// File: rtl/runahead_redirect_event_gen.sv
// Runahead redirect difftest event producer: episode tracking, checkpoint IDs, event FIFO.
// Optional same-cycle bypass to the sink: define RUNAHEAD_REDIRECT_BYPASS_EN.
module runahead_redirect_event_gen #(
  parameter int          DEPTH  = 4,
  parameter logic [7:0]  COREID = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_enter_valid,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_pc,
  input  logic [63:0] io_redirect_target,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [7:0]  io_out_coreid,
  output logic [63:0] io_out_pc,
  output logic [63:0] io_out_target_pc,
  output logic [63:0] io_out_checkpoint_id,
  output logic        io_busy,
  output logic        io_err,
  output logic [15:0] io_drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_NORMAL   = 1'b0;
  localparam logic [0:0] ST_RUNAHEAD = 1'b1;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic [63:0] id;
  } ev_t;

  logic [0:0]  state_q, state_d;
  logic [63:0] ckpt_q, ckpt_d;
  logic [63:0] cur_id_q, cur_id_d;
  logic        err_q, err_d;
  logic [15:0] drop_q, drop_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  ev_t         mem_q [DEPTH];
  ev_t         mem_d [DEPTH];

  logic empty;
  logic full;
  logic push_req;
  logic byp;
  logic pop_fifo;
  logic push_fifo;
  logic drop;
  ev_t  in_ev;
  ev_t  head_ev;
  ev_t  out_ev;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push_req = (state_q == ST_RUNAHEAD) && io_redirect_valid;
  assign in_ev    = '{pc: io_redirect_pc, tgt: io_redirect_target, id: cur_id_q};
  assign head_ev  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef RUNAHEAD_REDIRECT_BYPASS_EN
  assign byp = empty && push_req && io_out_ready;
`else
  assign byp = 1'b0;
`endif

  assign out_ev    = byp ? in_ev : head_ev;
  assign pop_fifo  = !empty && io_out_ready;
  assign push_fifo = push_req && !byp && (!full || pop_fifo);
  assign drop      = push_req && full && !pop_fifo;

  assign io_out_valid         = !empty || byp;
  assign io_out_coreid        = COREID;
  assign io_out_pc            = out_ev.pc;
  assign io_out_target_pc     = out_ev.tgt;
  assign io_out_checkpoint_id = out_ev.id;
  assign io_busy              = (state_q == ST_RUNAHEAD);
  assign io_err               = err_q;
  assign io_drop_cnt          = drop_q;

  always_comb begin
    state_d  = state_q;
    ckpt_d   = ckpt_q;
    cur_id_d = cur_id_q;
    err_d    = err_q;
    case (state_q)
      ST_NORMAL: begin
        if (io_enter_valid) begin
          cur_id_d = ckpt_q;
          ckpt_d   = ckpt_q + 64'd1;
          state_d  = ST_RUNAHEAD;
        end
        if (io_redirect_valid) err_d = 1'b1;
      end
      ST_RUNAHEAD: begin
        // Redirect+enter closes one episode and opens the next at once
        if (io_redirect_valid) begin
          if (io_enter_valid) begin
            cur_id_d = ckpt_q;
            ckpt_d   = ckpt_q + 64'd1;
          end else begin
            state_d = ST_NORMAL;
          end
        end else if (io_enter_valid) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (pop_fifo) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_fifo) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_ev;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_NORMAL;
      ckpt_q   <= '0;
      cur_id_q <= '0;
      err_q    <= 1'b0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ckpt_q   <= ckpt_d;
      cur_id_q <= cur_id_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_runahead_redirect_event_gen.sv
// Self-checking bench for runahead_redirect_event_gen.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_runahead_redirect_event_gen;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        enter;
  logic        redir;
  logic        ready;
  logic [63:0] rpc;
  logic [63:0] rtgt;
  logic        out_valid;
  logic [7:0]  out_coreid;
  logic [63:0] out_pc;
  logic [63:0] out_tgt;
  logic [63:0] out_id;
  logic        busy;
  logic        err;
  logic [15:0] drop_cnt;

  runahead_redirect_event_gen #(.DEPTH(DEPTH), .COREID(8'h5A)) dut (
    .clock(clock),
    .reset(reset),
    .io_enter_valid(enter),
    .io_redirect_valid(redir),
    .io_redirect_pc(rpc),
    .io_redirect_target(rtgt),
    .io_out_valid(out_valid),
    .io_out_ready(ready),
    .io_out_coreid(out_coreid),
    .io_out_pc(out_pc),
    .io_out_target_pc(out_tgt),
    .io_out_checkpoint_id(out_id),
    .io_busy(busy),
    .io_err(err),
    .io_drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic [63:0] id;
  } ev_t;

  ev_t         m_q[$];
  logic        m_busy;
  logic        m_err;
  logic [63:0] m_next;
  logic [63:0] m_cur;
  int          m_drop;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic m_byp();
`ifdef RUNAHEAD_REDIRECT_BYPASS_EN
    return (m_q.size() == 0) && m_busy && redir && ready;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_valid();
    return (m_q.size() > 0) || m_byp();
  endfunction

  function automatic ev_t exp_head();
    ev_t e;
    e = '{64'd0, 64'd0, 64'd0};
    if (m_byp()) e = '{rpc, rtgt, m_cur};
    else if (m_q.size() > 0) e = m_q[0];
    return e;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_next = '0;
    m_cur  = '0;
    m_drop = 0;
  endtask

  task automatic tick();
    logic v;
    logic b;
    ev_t  ev;
    v  = exp_valid();
    b  = m_byp();
    ev = '{rpc, rtgt, m_cur};
    if (!b) begin
      if (v && ready) void'(m_q.pop_front());
      if (m_busy && redir) begin
        if (m_q.size() < DEPTH) m_q.push_back(ev);
        else if (m_drop < 65535) m_drop++;
      end
    end
    if (!m_busy) begin
      if (redir) m_err = 1'b1;
      if (enter) begin
        m_cur  = m_next;
        m_next = m_next + 64'd1;
        m_busy = 1'b1;
      end
    end else if (redir) begin
      if (enter) begin
        m_cur  = m_next;
        m_next = m_next + 64'd1;
      end else begin
        m_busy = 1'b0;
      end
    end else if (enter) begin
      m_err = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic e, input logic r, input logic [63:0] pc,
                        input logic [63:0] tgt, input logic rdy);
    enter = e;
    redir = r;
    rpc   = pc;
    rtgt  = tgt;
    ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enter = 1'b0;
    redir = 1'b0;
    rpc   = '0;
    rtgt  = '0;
    ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'd0) $display("FAIL reset_pc: got %h want 0", out_pc); else n_pass++;
    n_total++; if (out_tgt !== 64'd0) $display("FAIL reset_tgt: got %h want 0", out_tgt); else n_pass++;
    n_total++; if (out_id !== 64'd0) $display("FAIL reset_id: got %h want 0", out_id); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %h want 0", drop_cnt); else n_pass++;
    n_total++; if (out_coreid !== 8'h5A) $display("FAIL coreid: got %h want 5a", out_coreid); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    set_in(0, 0, 0, 0, 1); tick();
    tick();
    set_in(1, 0, 0, 0, 1); tick();
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy3: got %b want 1", busy); else n_pass++;
    set_in(0, 0, 0, 0, 1); tick();
    tick();
    set_in(0, 1, 64'h8000_0100, 64'h8000_0200, 1);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy5: got %b want 1", busy); else n_pass++;
`ifdef RUNAHEAD_REDIRECT_BYPASS_EN
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_byp_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'h8000_0100) $display("FAIL basic_byp_pc: got %h want 80000100", out_pc); else n_pass++;
    n_total++; if (out_id !== 64'd0) $display("FAIL basic_byp_id: got %h want 0", out_id); else n_pass++;
`else
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_valid5: got %b want 0", out_valid); else n_pass++;
`endif
    tick();
    set_in(0, 0, 0, 0, 1);
`ifdef RUNAHEAD_REDIRECT_BYPASS_EN
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_valid6: got %b want 0", out_valid); else n_pass++;
`else
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid6: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'h8000_0100) $display("FAIL basic_pc: got %h want 80000100", out_pc); else n_pass++;
    n_total++; if (out_tgt !== 64'h8000_0200) $display("FAIL basic_tgt: got %h want 80000200", out_tgt); else n_pass++;
    n_total++; if (out_id !== 64'd0) $display("FAIL basic_id: got %h want 0", out_id); else n_pass++;
`endif
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy6: got %b want 0", busy); else n_pass++;
    tick();
  endtask

  task automatic test_episodes();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 1, 64'(k * 16), 64'(k * 32), 0); tick();
      set_in(0, 0, 0, 0, 1);
      n_total++; if (out_valid !== 1'b1) $display("FAIL ep%0d_valid: got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (out_id !== 64'(k)) $display("FAIL ep%0d_id: got %h want %h", k, out_id, 64'(k)); else n_pass++;
      tick();
    end
    n_total++; if (err !== 1'b0) $display("FAIL ep_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int k = 0; k < DEPTH + 2; k++) begin
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 1, 64'h1000 + 64'(k), 64'h2000 + 64'(k), 0); tick();
    end
    set_in(0, 0, 0, 0, 0);
    n_total++; if (drop_cnt !== 16'd2) $display("FAIL drop_cnt: got %0d want 2", drop_cnt); else n_pass++;
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < DEPTH; k++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL drain%0d_valid: got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (out_id !== 64'(k)) $display("FAIL drain%0d_id: got %h want %h", k, out_id, 64'(k)); else n_pass++;
      n_total++; if (out_pc !== 64'h1000 + 64'(k)) $display("FAIL drain%0d_pc: got %h want %h", k, out_pc, 64'h1000 + 64'(k)); else n_pass++;
      n_total++; if (out_tgt !== 64'h2000 + 64'(k)) $display("FAIL drain%0d_tgt: got %h want %h", k, out_tgt, 64'h2000 + 64'(k)); else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 1, 64'h3000 + 64'(k), 64'h4000 + 64'(k), 0); tick();
    end
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 64'h3000 + 64'(DEPTH), 64'h4000 + 64'(DEPTH), 1);
    n_total++; if (out_id !== 64'd0) $display("FAIL pp_head: got %h want 0", out_id); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 1);
    n_total++; if (drop_cnt !== 16'd0) $display("FAIL pp_drop: got %0d want 0", drop_cnt); else n_pass++;
    for (int k = 1; k <= DEPTH; k++) begin
      n_total++; if (out_id !== 64'(k)) $display("FAIL pp%0d_id: got %h want %h", k, out_id, 64'(k)); else n_pass++;
      n_total++; if (out_pc !== 64'h3000 + 64'(k)) $display("FAIL pp%0d_pc: got %h want %h", k, out_pc, 64'h3000 + 64'(k)); else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL pp_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_err();
    do_reset();
    set_in(0, 1, 64'h77, 64'h88, 0); tick();
    set_in(0, 0, 0, 0, 0);
    n_total++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL err_nopush: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL err_busy: got %b want 0", busy); else n_pass++;
    set_in(1, 0, 0, 0, 0); tick();
    tick();
    set_in(0, 0, 0, 0, 0);
    n_total++; if (busy !== 1'b1) $display("FAIL err_busy2: got %b want 1", busy); else n_pass++;
    set_in(0, 1, 64'h10, 64'h20, 0); tick();
    set_in(0, 0, 0, 0, 1);
    n_total++; if (out_id !== 64'd0) $display("FAIL err_id0: got %h want 0", out_id); else n_pass++;
    tick();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 64'h30, 64'h40, 0); tick();
    set_in(0, 0, 0, 0, 1);
    n_total++; if (out_id !== 64'd1) $display("FAIL err_id1: got %h want 1", out_id); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
    tick();
  endtask

  task automatic rand_inputs(input int rdy_pct);
    set_in(($urandom_range(99) < 40) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 40) ? 1'b1 : 1'b0,
           {$urandom, $urandom}, {$urandom, $urandom},
           (int'($urandom_range(99)) < rdy_pct) ? 1'b1 : 1'b0);
  endtask

  task automatic test_random();
    ev_t e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_inputs((c / 100) % 2 == 0 ? 25 : 85);
      e = exp_head();
      n_total++; if (out_valid !== exp_valid()) $display("FAIL rnd%0d_valid: got %b want %b", c, out_valid, exp_valid()); else n_pass++;
      if (exp_valid()) begin
        n_total++;
        if (out_pc !== e.pc || out_tgt !== e.tgt || out_id !== e.id)
          $display("FAIL rnd%0d_payload: got %h/%h/%h want %h/%h/%h", c, out_pc, out_tgt, out_id, e.pc, e.tgt, e.id);
        else n_pass++;
      end
      n_total++; if (busy !== m_busy) $display("FAIL rnd%0d_busy: got %b want %b", c, busy, m_busy); else n_pass++;
      n_total++; if (err !== m_err) $display("FAIL rnd%0d_err: got %b want %b", c, err, m_err); else n_pass++;
      n_total++; if (drop_cnt !== 16'(m_drop)) $display("FAIL rnd%0d_drop: got %0d want %0d", c, drop_cnt, m_drop); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      rand_inputs(20);
      tick();
    end
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 64'hABCD, 64'hDCBA, 0); tick();
    set_in(1, 0, 0, 0, 0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'd0) $display("FAIL mid_pc: got %h want 0", out_pc); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (err !== 1'b0 || drop_cnt !== 16'd0) $display("FAIL mid_err_drop: got %b/%0d want 0/0", err, drop_cnt); else n_pass++;
    @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 64'h5, 64'h6, 0); tick();
    set_in(0, 0, 0, 0, 1);
    n_total++; if (out_id !== 64'd0) $display("FAIL mid_ckpt: got %h want 0", out_id); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_episodes();
    test_full_drop();
    test_full_pop_push();
    test_err();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/runahead_redirect_event_gen.md
# runahead_redirect_event_gen

Producer side of the runahead redirect difftest event. It tracks runahead episodes from core control, allocates a 64-bit checkpoint ID for each episode, and records one event per runahead-ending redirect. Events are buffered in a small FIFO and drained one per cycle, with a valid/ready handshake, toward the per-core difftest event sink. It sits between the core's runahead controller and the difftest sink instance.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- COREID, 0, 8-bit value driven on io_out_coreid
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- io_enter_valid  in  1  core enters runahead this cycle
- io_redirect_valid  in  1  redirect ending runahead
- io_redirect_pc  in  64  PC of redirecting instruction
- io_redirect_target  in  64  redirect target PC
- io_out_valid  out  1  event available
- io_out_ready  in  1  sink accepts event
- io_out_coreid  out  8  constant COREID
- io_out_pc  out  64  event PC
- io_out_target_pc  out  64  event target
- io_out_checkpoint_id  out  64  checkpoint of the ended episode
- io_busy  out  1  state is RUNAHEAD
- io_err  out  1  sticky protocol error
- io_drop_cnt  out  16  saturating count of events lost to a full FIFO

## Operation
- States: NORMAL, RUNAHEAD. Reset → NORMAL.
- NORMAL with enter: cur_id ← ckpt_cnt; ckpt_cnt ← ckpt_cnt+1 (wraps 2^64−1→0); go to RUNAHEAD.
- RUNAHEAD with redirect: push {redirect_pc, redirect_target, cur_id}; go to NORMAL.
- Redirect and enter in the same cycle in RUNAHEAD: push the event with the old cur_id, allocate a new ID, stay in RUNAHEAD.
- Enter in RUNAHEAD without redirect: ignored; io_err set. Redirect in NORMAL: ignored, nothing pushed; io_err set.
- Enter and redirect together in NORMAL: redirect is treated as spurious (io_err set); enter is processed normally.
- FIFO: circular buffer with log2(DEPTH)+1-bit read/write pointers. Full when the pointers' MSBs differ and the low bits are equal.
- Pop occurs when io_out_valid && io_out_ready. Output fields come from the head entry.
- Push while full with no pop in the same cycle: event dropped; io_drop_cnt increments, saturating at 0xFFFF; the state transition still happens.
- Push while full with a pop in the same cycle: accepted.
- io_err is cleared only by reset.

## Timing
- Reset values:
  - io_out_valid=0
  - io_out_pc, io_out_target_pc and io_out_checkpoint_id all 0 (head registers are reset)
  - io_busy=0, io_err=0, io_drop_cnt=0
  - ckpt_cnt=0, cur_id=0, FIFO empty
- Push-to-output latency is 1 cycle: a redirect at cycle N gives io_out_valid at N+1.
- Sustained throughput is one event per cycle when io_out_ready=1.
- io_out_valid stays high and payload stays stable until accepted. No retraction.
- io_busy follows the registered state: it rises the cycle after enter and falls the cycle after redirect.
- Reset asserted mid-operation: all state clears immediately and asynchronously, including the FIFO contents and counters.

## Configuration
- RUNAHEAD_REDIRECT_BYPASS_EN defined: when the FIFO is empty, io_out_ready=1 and a push occurs, the event appears combinationally on the outputs in the same cycle and is not written to the FIFO. Latency is 0.
  - If io_out_ready=0 in that cycle, the event is written to the FIFO as normal.
- Undefined: no bypass; the 1-cycle latency always applies.

## Test plan
- Reset, then enter at cycle 2 and redirect (pc=0x8000_0100, target=0x8000_0200) at cycle 5 with ready=1 → io_out_valid at cycle 6 with those values and checkpoint_id=0; io_busy high for cycles 3–5.
- Three enter/redirect episodes → checkpoint_ids 0, 1, 2 in order; io_err=0.
- Hold ready=0 and run DEPTH+2 episodes → DEPTH events retained; io_drop_cnt=2; draining returns the first DEPTH in order, unchanged.
- FIFO full, ready=1, redirect in the same cycle → event accepted; io_drop_cnt unchanged.
- Redirect in NORMAL, then enter twice in a row → io_err=1; exactly one ID allocated; no event pushed.
- Macro defined, empty FIFO, ready=1, redirect at cycle N → io_out_valid at cycle N. Macro undefined → at N+1.
